// File: rtl/coproc_sram_arb_pkg.sv
// Shared types and helpers for the coprocessor SRAM arbiter.
// Holds the arbiter state enum, default widths and the rotate-priority pick.
package coproc_sram_arb_pkg;

    typedef enum logic {
        ARB,
        HOLD
    } arb_state_e;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_REQ    = 8;
    localparam int IDX_W      = 3;

    // One-hot grant: first requester set in req, searching upward
    // from (last+1) mod n and wrapping.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   last,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && req[idx[IDX_W-1:0]]) begin
                gnt[idx[IDX_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/coproc_sram_arbiter_picker.sv
// Combinational rotate-priority encoder for N_REQ requesters.
// Ports: req_i (requests), last_i (last grant) -> gnt_o (one-hot), idx_o, valid_o.
module coproc_rr_picker
    import coproc_sram_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req_i;
        gnt_ext              = rr_pick(req_ext, last_i, N_REQ);
        gnt_o                = gnt_ext[N_REQ-1:0];
        idx_o                = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (gnt_ext[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        valid_o = |gnt_ext;
    end

endmodule

// File: rtl/coproc_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between N_REQ Avalon-MM
// requesters; one command per cycle, 1-cycle read latency, one-hot readdatavalid.
// Ports: clk, reset_n (async low); req_* per-requester command/response buses;
// quiesce blocks new grants; idle; sram_* drive the SRAM, sram_readdata returns.
// Optional feature macro SRAM_ARB_LOCK_EN: req_lock pins the grant to its owner.
module coproc_sram_arbiter
    import coproc_sram_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ*ADDR_W-1:0]   req_address,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*DATA_W-1:0]   req_writedata,
    input  logic [N_REQ*DATA_W/8-1:0] req_byteenable,
    input  logic [N_REQ-1:0]          req_lock,
    output logic [N_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [N_REQ-1:0]          req_readdatavalid,
    input  logic                      quiesce,
    output logic                      idle,
    output logic [ADDR_W-1:0]         sram_address,
    output logic [DATA_W/8-1:0]       sram_byteenable,
    output logic                      sram_chipselect,
    output logic                      sram_write,
    output logic [DATA_W-1:0]         sram_writedata,
    output logic                      sram_clken,
    input  logic [DATA_W-1:0]         sram_readdata
);

    localparam int BE_W = DATA_W / 8;

    logic [N_REQ-1:0] active;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] g_idx;
    logic             accept;

    logic [IDX_W-1:0] last_q, last_d;
    logic             rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0] rd_id_q, rd_id_d;

    assign active = req_read | req_write;

`ifdef SRAM_ARB_LOCK_EN
    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [N_REQ-1:0] owner_oh;
    logic             pinned;
    logic             lock_g;

    // The owner stays pinned while it still requests or holds lock;
    // once it drops both, the others may win in that same cycle.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
        pinned   = (state_q == HOLD) && |(owner_oh & (active | req_lock));
        cand     = pinned ? (active & owner_oh) : active;
    end

    assign lock_g = |(gnt & req_lock);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
            owner_q <= '0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (accept && lock_g) begin
                        state_q <= HOLD;
                        owner_q <= g_idx;
                    end
                end
                HOLD: begin
                    if (pinned) begin
                        if (accept && !lock_g) begin
                            state_q <= ARB;
                        end
                    end else if (accept && lock_g) begin
                        owner_q <= g_idx;
                    end else begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign cand        = active;
`endif

    // Grants are suppressed while in reset or quiesced.
    assign eligible = (reset_n && !quiesce) ? cand : '0;

    coproc_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i   (eligible),
        .last_i  (last_q),
        .gnt_o   (gnt),
        .idx_o   (g_idx),
        .valid_o (accept)
    );

    always_comb begin
        sram_address    = '0;
        sram_byteenable = '0;
        sram_writedata  = '0;
        sram_write      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sram_address    = req_address[i*ADDR_W +: ADDR_W];
                sram_byteenable = req_byteenable[i*BE_W +: BE_W];
                sram_writedata  = req_writedata[i*DATA_W +: DATA_W];
                sram_write      = req_write[i];
            end
        end
    end

    assign sram_chipselect = accept;
    assign sram_clken      = reset_n;
    assign req_waitrequest = ~gnt;
    assign idle            = !rd_pend_q && !accept;

    always_comb begin
        last_d    = accept ? g_idx : last_q;
        rd_pend_d = accept && !sram_write;
        rd_id_d   = accept ? g_idx : rd_id_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= IDX_W'(N_REQ - 1);
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Read data is gated so the bus reads zero whenever no response is due.
    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_readdatavalid[i] = rd_pend_q && (rd_id_q == IDX_W'(i));
        end
        req_readdata = rd_pend_q ? sram_readdata : '0;
    end

endmodule

// File: tb/tb_coproc_sram_arbiter.sv
// Self-checking bench for coproc_sram_arbiter with a behavioural SRAM,
// a vector table, a read-response scoreboard and hand-written corner sequences.
module tb_coproc_sram_arbiter;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_writedata;
    logic [N*BW-1:0] req_byteenable;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_waitrequest;
    logic [DW-1:0]   req_readdata;
    logic [N-1:0]    req_readdatavalid;
    logic            quiesce;
    logic            idle;
    logic [AW-1:0]   sram_address;
    logic [BW-1:0]   sram_byteenable;
    logic            sram_chipselect;
    logic            sram_write;
    logic [DW-1:0]   sram_writedata;
    logic            sram_clken;
    logic [DW-1:0]   sram_readdata;

    always #5 clk = ~clk;

    coproc_sram_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_byteenable    (req_byteenable),
        .req_lock          (req_lock),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .quiesce           (quiesce),
        .idle              (idle),
        .sram_address      (sram_address),
        .sram_byteenable   (sram_byteenable),
        .sram_chipselect   (sram_chipselect),
        .sram_write        (sram_write),
        .sram_writedata    (sram_writedata),
        .sram_clken        (sram_clken),
        .sram_readdata     (sram_readdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 1023) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Behavioural SRAM: registered read, byte-enabled write.
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        sram_readdata = '0;
        forever begin
            @(posedge clk);
            if (sram_chipselect) begin
                if (sram_write) begin
                    for (int b = 0; b < BW; b++)
                        if (sram_byteenable[b])
                            mem[sram_address][b*8 +: 8] <= sram_writedata[b*8 +: 8];
                end else begin
                    sram_readdata <= mem[sram_address];
                end
            end
        end
    end

    // Stimulus state
    logic [N-1:0]  rd, wr, lk;
    logic          q;
    logic [AW-1:0] a  [N];
    logic [DW-1:0] d  [N];
    logic [BW-1:0] be [N];

    // Reference model state
    logic [31:0] exp_mem [1024];
    int          exp_last;
    logic        m_hold;
    int          m_owner;

    typedef struct {
        int          id;
        logic [31:0] data;
    } sb_t;
    sb_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        req_read    = rd;
        req_write   = wr;
        req_lock    = lk;
        quiesce     = q;
        req_address = {a[1], a[0]};
        req_writedata  = {d[1], d[0]};
        req_byteenable = {be[1], be[0]};
    endtask

    function automatic int model_grant();
        logic [N-1:0] act;
        act = rd | wr;
        if (q || !reset_n) return -1;
        if (m_hold && (act[m_owner] || lk[m_owner]))
            return act[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (exp_last + k) % N;
            if (act[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        int          g;
        sb_t         e;
        logic [N-1:0] exp_rv;
        logic [N-1:0] ew;
        logic [31:0] exp_rd;
        @(negedge clk);
        apply();
        #1;
        exp_rv = '0;
        exp_rd = '0;
        if (sb.size() > 0) begin
            e      = sb.pop_front();
            exp_rv = '0;
            exp_rv[e.id] = 1'b1;
            exp_rd = e.data;
        end
        check("readdatavalid", 64'(req_readdatavalid), 64'(exp_rv));
        if (exp_rv != '0)
            check("readdata", 64'(req_readdata), 64'(exp_rd));
        g  = model_grant();
        ew = '1;
        if (g >= 0) ew[g] = 1'b0;
        check("waitrequest", 64'(req_waitrequest), 64'(ew));
        check("chipselect", 64'(sram_chipselect), 64'(g >= 0));
        check("idle", 64'(idle), 64'((exp_rv == '0) && (g < 0)));
        if (g >= 0) begin
            check("sram_write", 64'(sram_write), 64'(wr[g]));
            check("sram_address", 64'(sram_address), 64'(a[g]));
            if (wr[g]) begin
                check("sram_writedata", 64'(sram_writedata), 64'(d[g]));
                check("sram_byteenable", 64'(sram_byteenable), 64'(be[g]));
                for (int b = 0; b < BW; b++)
                    if (be[g][b]) exp_mem[a[g]][b*8 +: 8] = d[g][b*8 +: 8];
            end else begin
                sb.push_back('{g, exp_mem[a[g]]});
            end
            if (!m_hold) begin
                if (lk[g]) begin
                    m_hold  = 1'b1;
                    m_owner = g;
                end
            end else if (g == m_owner) begin
                if (!lk[g]) m_hold = 1'b0;
            end else if (lk[g]) begin
                m_owner = g;
            end else begin
                m_hold = 1'b0;
            end
            exp_last = g;
        end else if (m_hold && !(rd[m_owner] | wr[m_owner]) && !lk[m_owner]) begin
            m_hold = 1'b0;
        end
    endtask

    typedef struct {
        logic [N-1:0]  rd;
        logic [N-1:0]  wr;
        logic          q;
        logic [31:0]   d0;
        logic [31:0]   d1;
        logic [N-1:0]  ew;
        logic          ecs;
        logic          ewe;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0};
        tbl[1]  = '{2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0};
        tbl[4]  = '{2'b01, 2'b00, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0};
        tbl[5]  = '{2'b01, 2'b00, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0};
        tbl[6]  = '{2'b10, 2'b00, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0};
        tbl[8]  = '{2'b11, 2'b00, 1'b1, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 2'b10, 1'b0, 32'h0, 32'h11112222, 2'b01, 1'b1, 1'b1};
        tbl[11] = '{2'b11, 2'b11, 1'b0, 32'h33334444, 32'h55556666, 2'b10, 1'b1, 1'b1};
        tbl[12] = '{2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0};
        tbl[13] = '{2'b01, 2'b00, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0};
        tbl[14] = '{2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0};

        for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
        exp_last = N - 1;
        m_hold   = 1'b0;
        m_owner  = 0;
        rd = 2'b11; wr = '0; lk = '0; q = 1'b0;
        a[0] = 10'h010; a[1] = 10'h020;
        d[0] = '0; d[1] = '0;
        be[0] = 4'hF; be[1] = 4'hF;

        // Reset with both requesters reading
        reset_n = 1'b0;
        apply();
        #12;
        check("rst_wait", 64'(req_waitrequest), 64'(2'b11));
        check("rst_cs", 64'(sram_chipselect), 64'(1'b0));
        check("rst_we", 64'(sram_write), 64'(1'b0));
        check("rst_clken", 64'(sram_clken), 64'(1'b0));
        check("rst_rdv", 64'(req_readdatavalid), 64'(2'b00));
        check("rst_rdata", 64'(req_readdata), 64'(0));
        @(negedge clk);
        rd = '0;
        apply();
        reset_n = 1'b1;
        #1;
        check("clken_run", 64'(sram_clken), 64'(1'b1));

        // Table-driven main function
        for (int i = 0; i < 15; i++) begin
            rd = tbl[i].rd; wr = tbl[i].wr; q = tbl[i].q;
            d[0] = tbl[i].d0; d[1] = tbl[i].d1;
            step();
            check($sformatf("tbl%0d_wait", i), 64'(req_waitrequest), 64'(tbl[i].ew));
            check($sformatf("tbl%0d_cs", i), 64'(sram_chipselect), 64'(tbl[i].ecs));
            check($sformatf("tbl%0d_we", i), 64'(sram_write), 64'(tbl[i].ewe));
        end

        // Partial write then read back at top address
        rd = '0; wr = 2'b01; a[0] = 10'h3FF; d[0] = 32'hDEAD_BEEF; be[0] = 4'b0011;
        step();
        check("bw_wait0", 64'(req_waitrequest), 64'(2'b10));
        wr = '0; rd = 2'b10; a[1] = 10'h3FF;
        step();
        check("bw_wait1", 64'(req_waitrequest), 64'(2'b01));
        rd = '0; be[0] = 4'hF;
        step();
        check("bw_rdv", 64'(req_readdatavalid), 64'(2'b10));
        check("bw_rdata", 64'(req_readdata), 64'(32'h0000_BEEF));

        // Quiesce with reads pending
        rd = 2'b11; a[0] = 10'h010; a[1] = 10'h020; q = 1'b0;
        step();
        q = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("q%0d_cs", k), 64'(sram_chipselect), 64'(1'b0));
            if (k == 0)
                check("q_ret_rdv", 64'(req_readdatavalid), 64'(2'b01));
            else
                check($sformatf("q%0d_idle", k), 64'(idle), 64'(1'b1));
        end
        q = 1'b0;
        step();
        check("q_resume", 64'(req_waitrequest), 64'(2'b01));
        rd = '0;
        step();

`ifdef SRAM_ARB_LOCK_EN
        // Locked writer starves the other requester for 4 accepts
        rd = 2'b10;
        step();
        for (int k = 0; k < 4; k++) begin
            wr = 2'b01; lk = 2'b01; rd = 2'b10; a[0] = AW'(10'h100 + k);
            d[0] = 32'hA000_0000 | 32'(k);
            step();
            check($sformatf("lk%0d_wait", k), 64'(req_waitrequest), 64'(2'b10));
        end
        wr = '0; lk = '0; rd = 2'b10;
        step();
        check("lk_release", 64'(req_waitrequest), 64'(2'b01));
        rd = '0;
        step();
`endif

        // Reset pulse right after a read accept
        rd = 2'b01; a[0] = 10'h010;
        step();
        @(negedge clk);
        rd = '0;
        apply();
        reset_n = 1'b0;
        #1;
        check("rp_rdv", 64'(req_readdatavalid), 64'(2'b00));
        check("rp_wait", 64'(req_waitrequest), 64'(2'b11));
        check("rp_clken", 64'(sram_clken), 64'(1'b0));
        sb.delete();
        exp_last = N - 1;
        m_hold   = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        rd = 2'b11;
        step();
        check("rp_first", 64'(req_waitrequest), 64'(2'b10));
        rd = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
